if_fetch: RTL and testbench
===========================

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter RESET_PC, default 12'h000: byte address fetched first after reset.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 stall  input  1  hazard hold: freeze the PC and the decode-side register.
REQ-005 redirect  input  1  branch/jump taken; redirect_pc is valid this cycle.
REQ-006 redirect_pc  input  12  target byte address; bits [1:0] are ignored.
REQ-007 halt  input  1  stop fetching (syscall halt from decode).
REQ-008 imem_addr  output  10  instruction memory word address.
REQ-009 imem_req  output  1  read request; data returns on imem_rdata the next cycle.
REQ-010 imem_rdata  input  32  instruction word for the previous cycle's imem_addr.
REQ-011 pc_4  output  12  address of the presented instruction plus 4.
REQ-012 instruction  output  32  presented instruction word.
REQ-013 go  output  1  load enable for the IF/ID register.
REQ-014 clear  output  1  bubble select for the IF/ID register (load zeros).
REQ-015 halted  output  1  fetch is permanently stopped.

Function
REQ-016 The FSM SHALL have the states BOOT, RUN, HOLD and HALT.
REQ-017 State req_pc (12b) SHALL hold the address issued this cycle; out_pc (12b) SHALL hold the address of the returning word; out_valid SHALL flag it.
REQ-018 imem_addr SHALL equal req_pc[11:2]; imem_req SHALL be 1 in every state except HALT.
REQ-019 BOOT (one cycle after reset) SHALL issue RESET_PC, keep out_valid=0, drive go=1 and clear=1, and go to RUN.
REQ-020 RUN with no stall SHALL update req_pc<=req_pc+4, out_pc<=req_pc and out_valid<=1, and drive go=1.
REQ-021 PC arithmetic SHALL be modulo 4096: 12'hFFC+4 = 12'h000, and pc_4 wraps the same way.
REQ-022 instruction SHALL be imem_rdata in RUN and the hold register in HOLD; pc_4 SHALL be out_pc+4.
REQ-023 stall in RUN SHALL capture imem_rdata into the 32b hold register, hold req_pc and out_pc, drive go=0, and go to HOLD.
REQ-024 HOLD SHALL keep go=0 while stall=1; on stall=0 it SHALL drive go=1 with the hold-register word and return to RUN with req_pc and out_pc advanced as in REQ-020.
REQ-025 redirect (any of BOOT/RUN/HOLD) SHALL override stall and:
  - drive go=1, clear=1;
  - load req_pc<={redirect_pc[11:2],2'b00}, out_valid<=0;
  - discard the hold register and enter RUN.
REQ-026 clear SHALL be 1 whenever go=1 and out_valid=0.
REQ-027 halt with out_valid=1 SHALL enter HALT on the next edge; halt SHALL override redirect and stall in the same cycle.
REQ-028 HALT SHALL drive go=1, clear=1, imem_req=0 and halted=1, and SHALL be left only by reset.
REQ-029 Latency: an address issued in cycle N SHALL be presented on instruction/pc_4 in cycle N+1, absent stall or redirect.

Reset
REQ-030 rst_n=0 at a clock edge, including mid-HOLD or in HALT, SHALL set:
  - state=BOOT, req_pc=RESET_PC, out_pc=RESET_PC;
  - out_valid=0, hold register=0.
REQ-031 Outputs during reset SHALL be go=0, clear=1, halted=0, imem_req=0, instruction=0, pc_4=RESET_PC+4.

Configuration
REQ-032 With FETCH_PERF_EN defined, the block SHALL add two outputs, each cleared by reset:
  - fetch_count (32b, wrapping): increments on each go=1 & clear=0;
  - stall_count (16b, saturating at 16'hFFFF): increments on each cycle in HOLD.
REQ-033 Without FETCH_PERF_EN, those ports and counters SHALL be absent, with identical remaining behaviour.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding, the PC width constant (12), the instruction width constant (32), and the NOP constant 32'h0000_0000.
REQ-035 The optional counters SHALL sit in one sub-module, fetch_perf_counters; the block has no other sub-modules.

Verification
REQ-036 Reset release, RESET_PC=0, memory word[i]=i -> cycle 2: pc_4=12'h004, instruction=0; cycle 3: pc_4=12'h008, instruction=1.
REQ-037 stall high for 3 cycles while instruction=5 -> go=0 for 3 cycles, instruction stays 5; the next cycle gives go=1, instruction=5, then 6.
REQ-038 redirect with redirect_pc=12'h103 during a stall -> go=1, clear=1; imem_addr=10'h040 next cycle; the following cycle gives pc_4=12'h104.
REQ-039 Fetch from 12'hFF8 -> pc_4 sequence 12'hFFC, 12'h000, 12'h004.
REQ-040 halt and redirect in the same cycle -> HALT: halted=1, imem_req=0, clear=1 in every later cycle until rst_n=0.
REQ-041 FETCH_PERF_EN: 10 unstalled fetches, then 70000 stall cycles -> fetch_count=10, stall_count=16'hFFFF.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package if_fetch_pkg;

    localparam int unsigned PC_W        = 12;
    localparam int unsigned INSTR_W     = 32;
    localparam int unsigned WADDR_W     = PC_W - 2;
    localparam int unsigned FETCH_CNT_W = 32;
    localparam int unsigned STALL_CNT_W = 16;

    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

    // Fetch controller states.
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_HALT = 2'd3
    } fetch_state_e;

    // Next sequential byte address; wraps modulo the PC width.
    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + PC_W'(4);
    endfunction

    // Force a byte address onto a word boundary.
    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] pc);
        return {pc[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_perf_counters.sv
// Optional fetch performance counters, present only when FETCH_PERF_EN is defined.
//   fetch_count: wrapping count of real instructions handed to decode.
//   stall_count: saturating count of cycles spent holding for a hazard.
`ifdef FETCH_PERF_EN
module fetch_perf_counters
    import if_fetch_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   fetch_pulse,
    input  logic                   hold_pulse,
    output logic [FETCH_CNT_W-1:0] fetch_count,
    output logic [STALL_CNT_W-1:0] stall_count
);

    // Count delivered instructions (wrapping) and hold cycles (saturating).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            if (fetch_pulse) begin
                fetch_count <= fetch_count + FETCH_CNT_W'(1);
            end
            if (hold_pulse && (stall_count != {STALL_CNT_W{1'b1}})) begin
                stall_count <= stall_count + STALL_CNT_W'(1);
            end
        end
    end

endmodule
`endif

// File: rtl/if_fetch.sv
// Instruction fetch stage: issues word addresses to a one-cycle-latency
// instruction memory and presents the returning word to the IF/ID register.
// Optional feature macro: FETCH_PERF_EN adds fetch_count/stall_count outputs.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 12'h000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               halt,
    output logic [WADDR_W-1:0] imem_addr,
    output logic               imem_req,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [PC_W-1:0]    pc_4,
    output logic [INSTR_W-1:0] instruction,
    output logic               go,
    output logic               clear,
    output logic               halted
`ifdef FETCH_PERF_EN
    ,
    output logic [FETCH_CNT_W-1:0] fetch_count,
    output logic [STALL_CNT_W-1:0] stall_count
`endif
);

    fetch_state_e       state_q, state_d;
    logic [PC_W-1:0]    req_pc_q, req_pc_d;
    logic [PC_W-1:0]    out_pc_q, out_pc_d;
    logic               out_valid_q, out_valid_d;
    logic [INSTR_W-1:0] hold_q, hold_d;
    logic [PC_W-1:0]    req_pc_inc;

    // The low target bits are dropped when the redirect address is word-aligned.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign req_pc_inc = pc_inc(req_pc_q);
    assign imem_addr  = req_pc_q[PC_W-1:2];

    // During reset the presented PC is pinned to the boot address.
    assign pc_4 = rst_n ? pc_inc(out_pc_q) : pc_inc(RESET_PC);

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_BOOT;
            req_pc_q    <= RESET_PC;
            out_pc_q    <= RESET_PC;
            out_valid_q <= 1'b0;
            hold_q      <= NOP;
        end else begin
            state_q     <= state_d;
            req_pc_q    <= req_pc_d;
            out_pc_q    <= out_pc_d;
            out_valid_q <= out_valid_d;
            hold_q      <= hold_d;
        end
    end

    // Next-state, PC sequencing and IF/ID control.
    always_comb begin
        state_d     = state_q;
        req_pc_d    = req_pc_q;
        out_pc_d    = out_pc_q;
        out_valid_d = out_valid_q;
        hold_d      = hold_q;
        go          = 1'b0;
        clear       = 1'b0;
        imem_req    = 1'b0;
        halted      = 1'b0;
        instruction = NOP;

        if (!rst_n) begin
            clear = 1'b1;
        end else if (state_q == ST_HALT) begin
            // Fetch is parked: keep feeding bubbles until reset.
            go     = 1'b1;
            clear  = 1'b1;
            halted = 1'b1;
        end else begin
            imem_req = 1'b1;

            case (state_q)
                ST_RUN:  instruction = imem_rdata;
                ST_HOLD: instruction = hold_q;
                default: instruction = NOP;
            endcase

            if (halt && out_valid_q) begin
                // Halt wins over redirect and stall; younger fetches are squashed.
                go      = 1'b1;
                clear   = 1'b1;
                state_d = ST_HALT;
            end else if (redirect) begin
                // Wrong-path word in flight is squashed; target returns next cycle.
                go          = 1'b1;
                clear       = 1'b1;
                req_pc_d    = word_align(redirect_pc);
                out_valid_d = 1'b0;
                hold_d      = NOP;
                state_d     = ST_RUN;
            end else begin
                case (state_q)
                    ST_BOOT: begin
                        go          = 1'b1;
                        clear       = 1'b1;
                        req_pc_d    = req_pc_inc;
                        out_pc_d    = req_pc_q;
                        out_valid_d = 1'b1;
                        state_d     = ST_RUN;
                    end
                    ST_RUN: begin
                        if (stall) begin
                            // Memory will move on, so park the current word.
                            hold_d  = imem_rdata;
                            state_d = ST_HOLD;
                        end else begin
                            go          = 1'b1;
                            clear       = ~out_valid_q;
                            req_pc_d    = req_pc_inc;
                            out_pc_d    = req_pc_q;
                            out_valid_d = 1'b1;
                        end
                    end
                    ST_HOLD: begin
                        if (!stall) begin
                            go          = 1'b1;
                            clear       = ~out_valid_q;
                            req_pc_d    = req_pc_inc;
                            out_pc_d    = req_pc_q;
                            out_valid_d = 1'b1;
                            state_d     = ST_RUN;
                        end
                    end
                    default: state_d = ST_HALT;
                endcase
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic fetch_pulse;
    logic hold_pulse;

    assign fetch_pulse = go & ~clear;
    assign hold_pulse  = rst_n & (state_q == ST_HOLD);

    fetch_perf_counters u_perf (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_pulse (fetch_pulse),
        .hold_pulse  (hold_pulse),
        .fetch_count (fetch_count),
        .stall_count (stall_count)
    );
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Directed self-checking bench for if_fetch (memory word[i] = i).
module tb_if_fetch;
    import if_fetch_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               stall;
    logic               redirect;
    logic [PC_W-1:0]    redirect_pc;
    logic               halt;
    logic [WADDR_W-1:0] imem_addr;
    logic               imem_req;
    logic [INSTR_W-1:0] imem_rdata = '0;
    logic [PC_W-1:0]    pc_4;
    logic [INSTR_W-1:0] instruction;
    logic               go;
    logic               clear;
    logic               halted;
`ifdef FETCH_PERF_EN
    logic [FETCH_CNT_W-1:0] fetch_count;
    logic [STALL_CNT_W-1:0] stall_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // One-cycle-latency instruction memory holding its own word index.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= 32'(imem_addr);
    end

    if_fetch #(.RESET_PC(12'h000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .imem_addr   (imem_addr),
        .imem_req    (imem_req),
        .imem_rdata  (imem_rdata),
        .pc_4        (pc_4),
        .instruction (instruction),
        .go          (go),
        .clear       (clear),
        .halted      (halted)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count (fetch_count),
        .stall_count (stall_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
        tick(); tick();
        #1;
        chk("rst_go", 32'(go), 32'd0);
        chk("rst_clear", 32'(clear), 32'd1);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_instr", instruction, 32'h0);
        chk("rst_pc4", 32'(pc_4), 32'h004);

        // BOOT cycle
        rst_n = 1'b1; #1;
        chk("boot_go", 32'(go), 32'd1);
        chk("boot_clear", 32'(clear), 32'd1);
        chk("boot_req", 32'(imem_req), 32'd1);
        chk("boot_addr", 32'(imem_addr), 32'h000);
`ifdef FETCH_PERF_EN
        chk("boot_fcnt", fetch_count, 32'd0);
`endif

        tick(); #1;
        chk("c2_pc4", 32'(pc_4), 32'h004);
        chk("c2_instr", instruction, 32'd0);
        chk("c2_clear", 32'(clear), 32'd0);
        tick(); #1;
        chk("c3_pc4", 32'(pc_4), 32'h008);
        chk("c3_instr", instruction, 32'd1);
        repeat (4) tick();
        #1;
        chk("c7_instr", instruction, 32'd5);
        chk("c7_pc4", 32'(pc_4), 32'h018);

        // Three stall cycles while instruction 5 is presented
        stall = 1'b1; #1;
        chk("st1_go", 32'(go), 32'd0);
        chk("st1_instr", instruction, 32'd5);
        tick(); #1;
        chk("st2_go", 32'(go), 32'd0);
        chk("st2_instr", instruction, 32'd5);
        tick(); #1;
        chk("st3_go", 32'(go), 32'd0);
        chk("st3_instr", instruction, 32'd5);
        tick(); stall = 1'b0; #1;
        chk("rel_go", 32'(go), 32'd1);
        chk("rel_clear", 32'(clear), 32'd0);
        chk("rel_instr", instruction, 32'd5);
        chk("rel_pc4", 32'(pc_4), 32'h018);
        tick(); #1;
        chk("after_instr", instruction, 32'd6);
        chk("after_pc4", 32'(pc_4), 32'h01C);

        // Redirect during a stall
        stall = 1'b1; #1;
        chk("pre_rd_go", 32'(go), 32'd0);
        tick(); redirect = 1'b1; redirect_pc = 12'h103; #1;
        chk("rd_go", 32'(go), 32'd1);
        chk("rd_clear", 32'(clear), 32'd1);
        tick(); redirect = 1'b0; stall = 1'b0; #1;
        chk("rd_addr", 32'(imem_addr), 32'h040);
        chk("rd_bubble", 32'(clear), 32'd1);
        tick(); #1;
        chk("rd_pc4", 32'(pc_4), 32'h104);
        chk("rd_instr", instruction, 32'h040);
        chk("rd_clear0", 32'(clear), 32'd0);

        // Wrap-around from 12'hFF8
        redirect = 1'b1; redirect_pc = 12'hFF8;
        tick(); redirect = 1'b0; #1;
        chk("wr_addr", 32'(imem_addr), 32'h3FE);
        tick(); #1;
        chk("wr_pc4_a", 32'(pc_4), 32'hFFC);
        chk("wr_instr_a", instruction, 32'h3FE);
        tick(); #1;
        chk("wr_pc4_b", 32'(pc_4), 32'h000);
        chk("wr_instr_b", instruction, 32'h3FF);
        tick(); #1;
        chk("wr_pc4_c", 32'(pc_4), 32'h004);
        chk("wr_instr_c", instruction, 32'h000);

        // Halt together with redirect: halt wins, HALT is sticky
        halt = 1'b1; redirect = 1'b1; redirect_pc = 12'h200;
        tick(); halt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            redirect = i[0];
            stall    = i[1];
            #1;
            chk("hlt_halted", 32'(halted), 32'd1);
            chk("hlt_req", 32'(imem_req), 32'd0);
            chk("hlt_clear", 32'(clear), 32'd1);
            chk("hlt_go", 32'(go), 32'd1);
            tick();
        end

        // Reset out of HALT
        rst_n = 1'b0; redirect = 1'b0; stall = 1'b0; #1;
        chk("hrst_halted", 32'(halted), 32'd0);
        chk("hrst_go", 32'(go), 32'd0);
        chk("hrst_clear", 32'(clear), 32'd1);
        chk("hrst_req", 32'(imem_req), 32'd0);
        chk("hrst_pc4", 32'(pc_4), 32'h004);
        tick(); rst_n = 1'b1; #1;
        chk("reboot_go", 32'(go), 32'd1);
        chk("reboot_clear", 32'(clear), 32'd1);
        chk("reboot_halted", 32'(halted), 32'd0);
        chk("reboot_addr", 32'(imem_addr), 32'h000);
        tick(); #1;
        chk("reboot_pc4", 32'(pc_4), 32'h004);
        chk("reboot_instr", instruction, 32'd0);
        chk("reboot_go1", 32'(go), 32'd1);

`ifdef FETCH_PERF_EN
        // 10 delivered fetches, then a long hold that saturates stall_count
        repeat (10) tick();
        stall = 1'b1; #1;
        chk("perf_fcnt10", fetch_count, 32'd10);
        repeat (70000) @(posedge clk);
        #1;
        chk("perf_fcnt", fetch_count, 32'd10);
        chk("perf_scnt", 32'(stall_count), 32'h0000_FFFF);
        stall = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
